// File: rtl/alu_mdu_if.sv
// alu_mdu_if: request/response bundle between a requester and alu_mdu
//   master: drives in_valid, aluop, func, a, b, shamt; observes in_ready, out_valid,
//           result, zero, illegal, busy
//   slave : the mirror image, used by alu_mdu
interface alu_mdu_if #(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = $clog2(WIDTH)
);
   logic               in_valid;
   logic               in_ready;
   logic [1:0]         aluop;
   logic [5:0]         func;
   logic [WIDTH-1:0]   a;
   logic [WIDTH-1:0]   b;
   logic [SHAMT_W-1:0] shamt;
   logic               out_valid;
   logic [WIDTH-1:0]   result;
   logic               zero;
   logic               illegal;
   logic               busy;
   modport master (
      output in_valid, aluop, func, a, b, shamt,
      input  in_ready, out_valid, result, zero, illegal, busy
   );
   modport slave (
      input  in_valid, aluop, func, a, b, shamt,
      output in_ready, out_valid, result, zero, illegal, busy
   );
endinterface

// File: rtl/alu_mdu.sv
// alu_mdu: single-cycle ALU plus iterative unsigned multiply/divide with HI/LO
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : alu_mdu_if.slave (valid/ready request in, registered result/zero/illegal out,
//           out_valid one-cycle pulse, busy during MUL/DIV)
//   Macro ALU_MDU_DIV_EN enables the restoring divider (DIVU); without it DIVU is illegal.
module alu_mdu #(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = $clog2(WIDTH)
) (
   input logic    clk,
   input logic    rst_n,
   alu_mdu_if.slave bus
);
   typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
   state_t state, state_nxt;
   logic [WIDTH-1:0]   hi, lo, m, res_nxt, result_q;
   logic [2*WIDTH-1:0] p, p_mul, p_step;
   logic [WIDTH:0]     msum;
   logic [SHAMT_W-1:0] cnt;
   logic               ill_nxt, is_mul, is_div, div0, accept, last, zero_q, ill_q;
   assign accept        = bus.in_valid && bus.in_ready;
   assign last          = cnt == SHAMT_W'(WIDTH-1);
   assign bus.in_ready  = rst_n && state == IDLE;
   assign bus.out_valid = state == DONE;
   assign bus.busy      = state == MUL || state == DIV;
   assign bus.result    = result_q;
   assign bus.zero      = zero_q;
   assign bus.illegal   = ill_q;
   // p holds {partial product, remaining multiplier}; one multiplier bit retired per cycle
   assign msum  = {1'b0, p[2*WIDTH-1:WIDTH]} + {1'b0, p[0] ? m : '0};
   assign p_mul = {msum, p[WIDTH-1:1]};
`ifdef ALU_MDU_DIV_EN
   logic [WIDTH:0] rsh, rdiff;
   // p holds {remainder, dividend/quotient}; shift in next dividend bit, restore on borrow
   assign rsh    = p[2*WIDTH-1:WIDTH-1];
   assign rdiff  = rsh - {1'b0, m};
   assign p_step = state == DIV ? (rdiff[WIDTH] ? {rsh[WIDTH-1:0], p[WIDTH-2:0], 1'b0}
                                                : {rdiff[WIDTH-1:0], p[WIDTH-2:0], 1'b1})
                                : p_mul;
`else
   assign p_step = p_mul;
`endif
   always_comb begin
      res_nxt = '0;
      ill_nxt = 1'b0;
      is_mul  = 1'b0;
      is_div  = 1'b0;
      div0    = 1'b0;
      if (!bus.aluop[1]) res_nxt = bus.aluop[0] ? bus.a - bus.b : bus.a + bus.b;
      else case (bus.func)
         6'b100000: res_nxt = bus.a + bus.b;
         6'b100010: res_nxt = bus.a - bus.b;
         6'b100100: res_nxt = bus.a & bus.b;
         6'b100101: res_nxt = bus.a | bus.b;
         6'b000000: res_nxt = bus.b << bus.shamt;
         6'b000010: res_nxt = bus.b >> bus.shamt;
         6'b101010: res_nxt = {{(WIDTH-1){1'b0}}, $signed(bus.a) < $signed(bus.b)};
         6'b010000: res_nxt = hi;
         6'b010010: res_nxt = lo;
         6'b011001: is_mul = 1'b1;
`ifdef ALU_MDU_DIV_EN
         6'b011011: begin
            is_div  = bus.b != '0;
            div0    = bus.b == '0;
            res_nxt = '1;
         end
`endif
         default: ill_nxt = 1'b1;
      endcase
   end
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:     if (accept) state_nxt = is_mul ? MUL : is_div ? DIV : DONE;
         MUL, DIV: if (last) state_nxt = DONE;
         default:  state_nxt = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else state <= state_nxt;
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         result_q <= '0;
         zero_q   <= 1'b1;
         ill_q    <= 1'b0;
         hi       <= '0;
         lo       <= '0;
         m        <= '0;
         p        <= '0;
         cnt      <= '0;
      end else if (accept) begin
         cnt <= '0;
         m   <= is_div ? bus.b : bus.a;
         p   <= {{WIDTH{1'b0}}, is_div ? bus.a : bus.b};
         if (!is_mul && !is_div) begin
            result_q <= res_nxt;
            zero_q   <= res_nxt == '0;
            ill_q    <= ill_nxt;
         end
         if (div0) begin
            hi <= bus.a;
            lo <= '1;
         end
      end else if (state == MUL || state == DIV) begin
         cnt <= cnt + SHAMT_W'(1);
         p   <= p_step;
         if (last) begin
            hi       <= p_step[2*WIDTH-1:WIDTH];
            lo       <= p_step[WIDTH-1:0];
            result_q <= p_step[WIDTH-1:0];
            zero_q   <= p_step[WIDTH-1:0] == '0;
            ill_q    <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_alu_mdu.sv
// tb_alu_mdu: directed and randomized checks of alu_mdu against an arithmetic reference model
module tb_alu_mdu;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int checks = 0;
   int failures = 0;
   logic [31:0] hi_m = '0, lo_m = '0;
`ifdef ALU_MDU_DIV_EN
   localparam bit DIV_EN = 1'b1;
`else
   localparam bit DIV_EN = 1'b0;
`endif
   alu_mdu_if #(.WIDTH(32)) bus ();
   alu_mdu #(.WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   // expected result/illegal/latency from the instruction semantics; updates model HI/LO
   task automatic model(input logic [1:0] ao, input logic [5:0] f, input logic [31:0] x, y,
                        input logic [4:0] s, output logic [31:0] r, output logic il, output int lat);
      r = '0;
      il = 1'b0;
      lat = 0;
      if (ao == 2'd0) r = x + y;
      else if (ao == 2'd1) r = x - y;
      else case (f)
         6'h20: r = x + y;
         6'h22: r = x - y;
         6'h24: r = x & y;
         6'h25: r = x | y;
         6'h00: r = y << s;
         6'h02: r = y >> s;
         6'h2a: r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
         6'h10: r = hi_m;
         6'h12: r = lo_m;
         6'h19: begin
            {hi_m, lo_m} = 64'(x) * 64'(y);
            r = lo_m;
            lat = 32;
         end
         6'h1b: begin
            if (!DIV_EN) il = 1'b1;
            else begin
               if (y == 0) begin
                  hi_m = x;
                  lo_m = '1;
               end else begin
                  hi_m = x % y;
                  lo_m = x / y;
                  lat = 32;
               end
               r = lo_m;
            end
         end
         default: il = 1'b1;
      endcase
   endtask
   // called at a negedge; returns at the negedge after the request is accepted
   task automatic issue(input logic [1:0] ao, input logic [5:0] f, input logic [31:0] x, y,
                        input logic [4:0] s, input string tag);
      int n = 0;
      bus.in_valid = 1'b1;
      bus.aluop = ao;
      bus.func = f;
      bus.a = x;
      bus.b = y;
      bus.shamt = s;
      while (!bus.in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk({tag, " accept_timeout"}, 64'(n < 100), 64'd1);
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask
   task automatic wait_res(input string tag, input logic [31:0] r, input logic il, input int lat,
                           input bit scramble);
      int n = 0, bc = 0, rdy = 0;
      while (bus.out_valid !== 1'b1 && n < 100) begin
         if (bus.busy) bc++;
         if (bus.in_ready) rdy++;
         if (scramble) begin
            bus.a = $urandom;
            bus.b = $urandom;
            bus.shamt = 5'($urandom);
         end
         @(negedge clk);
         n++;
      end
      chk({tag, " latency"}, 64'(n), 64'(lat));
      chk({tag, " busy_cycles"}, 64'(bc), 64'(lat));
      chk({tag, " ready_while_busy"}, 64'(rdy), 64'd0);
      chk({tag, " result"}, 64'(bus.result), 64'(r));
      chk({tag, " zero"}, 64'(bus.zero), 64'(r == 0));
      chk({tag, " illegal"}, 64'(bus.illegal), 64'(il));
      @(negedge clk);
      chk({tag, " pulse"}, 64'(bus.out_valid), 64'd0);
      chk({tag, " held"}, 64'(bus.result), 64'(r));
   endtask
   task automatic op(input logic [1:0] ao, input logic [5:0] f, input logic [31:0] x, y,
                     input logic [4:0] s, input string tag);
      logic [31:0] r;
      logic il;
      int lat;
      model(ao, f, x, y, s, r, il, lat);
      issue(ao, f, x, y, s, tag);
      wait_res(tag, r, il, lat, 1'b1);
   endtask
   initial begin
      logic [5:0] fl [12] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h00, 6'h02, 6'h2a,
                              6'h10, 6'h12, 6'h19, 6'h1b, 6'h3f};
      logic [31:0] r;
      logic il;
      int lat;
      bus.in_valid = 1'b0;
      bus.aluop = '0;
      bus.func = '0;
      bus.a = '0;
      bus.b = '0;
      bus.shamt = '0;
      repeat (3) @(negedge clk);
      chk("rst in_ready", 64'(bus.in_ready), 64'd0);
      chk("rst out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst busy", 64'(bus.busy), 64'd0);
      chk("rst result", 64'(bus.result), 64'd0);
      chk("rst zero", 64'(bus.zero), 64'd1);
      chk("rst illegal", 64'(bus.illegal), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle in_ready", 64'(bus.in_ready), 64'd1);
      op(2'b10, 6'h22, 32'd5, 32'd7, 5'd0, "sub_5_7");
      op(2'b10, 6'h2a, 32'hFFFF_FFFF, 32'd1, 5'd0, "slt_neg");
      op(2'b10, 6'h02, 32'd0, 32'h8000_0000, 5'd31, "srl_31");
      op(2'b00, 6'h3f, 32'hFFFF_FFFF, 32'd1, 5'd0, "add_wrap");
      op(2'b01, 6'h3f, 32'd0, 32'd1, 5'd0, "sub_wrap");
      op(2'b10, 6'h19, 32'hFFFF_FFFF, 32'd2, 5'd0, "multu_max");
      op(2'b10, 6'h10, 32'd0, 32'd0, 5'd0, "mfhi_mul");
      op(2'b10, 6'h12, 32'd0, 32'd0, 5'd0, "mflo_mul");
      op(2'b10, 6'h1b, 32'd100, 32'd7, 5'd0, "divu_100_7");
      op(2'b10, 6'h10, 32'd0, 32'd0, 5'd0, "mfhi_div");
      op(2'b10, 6'h12, 32'd0, 32'd0, 5'd0, "mflo_div");
      op(2'b10, 6'h1b, 32'd1234, 32'd0, 5'd0, "divu_by0");
      op(2'b10, 6'h10, 32'd0, 32'd0, 5'd0, "mfhi_div0");
      op(2'b10, 6'h12, 32'd0, 32'd0, 5'd0, "mflo_div0");
      op(2'b10, 6'h3f, 32'h1234, 32'h5678, 5'd3, "illegal_3f");
      op(2'b10, 6'h10, 32'd0, 32'd0, 5'd0, "mfhi_after_illegal");
      // request held during MULTU must wait until the unit is idle again
      model(2'b10, 6'h19, 32'd1000, 32'd3000, 5'd0, r, il, lat);
      issue(2'b10, 6'h19, 32'd1000, 32'd3000, 5'd0, "multu_hold");
      bus.in_valid = 1'b1;
      bus.func = 6'h22;
      bus.a = 32'd9;
      bus.b = 32'd4;
      wait_res("multu_hold", r, il, lat, 1'b0);
      op(2'b10, 6'h22, 32'd9, 32'd4, 5'd0, "held_sub");
      // reset in the middle of a multiply
      op(2'b10, 6'h19, 32'hDEAD_BEEF, 32'h1234_5678, 5'd0, "multu_pre_rst");
      issue(2'b10, 6'h19, 32'h0BAD_F00D, 32'h7777_7777, 5'd0, "multu_rst");
      repeat (9) @(negedge clk);
      chk("mid_mul busy", 64'(bus.busy), 64'd1);
      rst_n = 1'b0;
      @(negedge clk);
      chk("abort busy", 64'(bus.busy), 64'd0);
      chk("abort out_valid", 64'(bus.out_valid), 64'd0);
      chk("abort in_ready_low", 64'(bus.in_ready), 64'd0);
      chk("abort result", 64'(bus.result), 64'd0);
      chk("abort zero", 64'(bus.zero), 64'd1);
      rst_n = 1'b1;
      hi_m = '0;
      lo_m = '0;
      @(negedge clk);
      chk("post_rst out_valid", 64'(bus.out_valid), 64'd0);
      chk("post_rst in_ready", 64'(bus.in_ready), 64'd1);
      op(2'b10, 6'h10, 32'd0, 32'd0, 5'd0, "mfhi_rst");
      op(2'b10, 6'h12, 32'd0, 32'd0, 5'd0, "mflo_rst");
      for (int i = 0; i < 40; i++) begin
         logic [1:0] ao;
         logic [5:0] f;
         logic [31:0] x, y;
         ao = 2'($urandom_range(0, 5) > 3 ? $urandom_range(0, 1) : 2 + $urandom_range(0, 1));
         f = $urandom_range(0, 7) == 0 ? 6'($urandom) : fl[$urandom_range(0, 11)];
         x = $urandom_range(0, 3) == 0 ? 32'($urandom_range(0, 20)) : $urandom;
         y = $urandom_range(0, 3) == 0 ? 32'($urandom_range(0, 3)) : $urandom;
         op(ao, f, x, y, 5'($urandom), "rand");
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/alu_mdu.md
ALU_MDU -- requirements
Module: alu_mdu

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width in bits (SHALL be power of two, 8..64).
REQ-002 Parameter: SHAMT_W, default $clog2(WIDTH), shift-amount width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 in_valid  input  1  operation request present.
REQ-006 in_ready  output  1  unit can accept a request this cycle.
REQ-007 aluop  input  2  00=add, 01=sub, 10/11=decode func.
REQ-008 func  input  6  R-type function field.
REQ-009 a, b  input  WIDTH  operands (rs, rt).
REQ-010 shamt  input  SHAMT_W  shift amount for SLL/SRL (shifts b).
REQ-011 out_valid  output  1  one-cycle pulse: result/flags valid.
REQ-012 result  output  WIDTH  registered result.
REQ-013 zero  output  1  result == 0, registered with result.
REQ-014 illegal  output  1  unsupported func, registered with result.
REQ-015 busy  output  1  multicycle operation in progress.

Function
REQ-016 Request accepted on a cycle with in_valid && in_ready; in_ready SHALL equal (state == IDLE).
REQ-017 States: IDLE, MUL, DIV, DONE; IDLE->DONE for single-cycle ops, IDLE->MUL on MULTU, IDLE->DIV on DIVU, MUL/DIV->DONE after WIDTH iterations, DONE->IDLE unconditionally.
REQ-018 out_valid SHALL be 1 exactly in DONE; result/zero/illegal held stable from DONE until next acceptance.
REQ-019 Single-cycle latency: accept at cycle N -> out_valid at N+1; next accept possible at N+2.
REQ-020 Decode: ADD 100000 a+b, SUB 100010 a-b, AND 100100, OR 100101, SLL 000000 b<<shamt, SRL 000010 b>>shamt (logical), SLT 101010 signed a<b -> 1 else 0, MFHI 010000 result=HI, MFLO 010010 result=LO.
REQ-021 Add/sub SHALL wrap modulo 2^WIDTH; no overflow trap.
REQ-022 MULTU 011001: unsigned shift-add, one bit per cycle, WIDTH cycles in MUL; {HI,LO} = a*b (2*WIDTH bits); result = LO.
REQ-023 DIVU 011011: unsigned restoring, WIDTH cycles in DIV; LO = a/b, HI = a%b; result = LO.
REQ-024 DIVU with b==0: SHALL skip DIV (IDLE->DONE), LO = all ones, HI = a, illegal = 0.
REQ-025 Undefined func: result = 0, illegal = 1, HI/LO unchanged, single-cycle latency.
REQ-026 HI/LO SHALL update only on completion of MULTU/DIVU; MFHI/MFLO return last completed values.
REQ-027 busy SHALL be 1 exactly in MUL and DIV.
REQ-028 in_valid while in_ready==0 SHALL be ignored (no queueing); requester holds request.
REQ-029 Operands SHALL be captured at acceptance; later input changes do not affect an in-flight operation.

Reset
REQ-030 rst_n==0 at a rising edge: state=IDLE, result=0, zero=1, illegal=0, out_valid=0, busy=0, HI=LO=0, iteration counter=0.
REQ-031 Reset during MUL/DIV SHALL abort the operation with no out_valid and HI/LO zeroed.
REQ-032 in_ready SHALL be 0 while rst_n==0.

Configuration
REQ-033 Macro ALU_MDU_DIV_EN: when defined, DIVU implemented per REQ-023/024.
REQ-034 Without ALU_MDU_DIV_EN: no divider logic, DIV state unreachable; DIVU treated as undefined func per REQ-025.

Verification
REQ-035 aluop=10, func=SUB, a=5, b=7, WIDTH=32 -> out_valid 1 cycle later, result=0xFFFFFFFE, zero=0.
REQ-036 func=SLT, a=0xFFFFFFFF, b=1 -> result=1; func=SRL, b=0x80000000, shamt=31 -> result=1.
REQ-037 func=MULTU, a=0xFFFFFFFF, b=2 -> busy 32 cycles, in_ready 0 throughout, out_valid at cycle 33, result=0xFFFFFFFE; then MFHI -> result=1.
REQ-038 With ALU_MDU_DIV_EN: DIVU a=100, b=7 -> LO=14, HI=2 after 32 busy cycles; DIVU b=0 -> out_valid next cycle, MFLO=0xFFFFFFFF, MFHI=a.
REQ-039 rst_n low at MUL iteration 10 -> next cycle state IDLE, no out_valid, MFHI/MFLO return 0.
REQ-040 func=111111 -> illegal=1, result=0, zero=1; in_valid held during busy -> not accepted until in_ready returns.
